// File: rtl/pm_min_scheduler_pkg.sv
// Shared parameters, FSM encoding and modular compare for the path-metric min search.
package pm_min_scheduler_pkg;

  localparam int unsigned SM_W       = 8;
  localparam int unsigned LANES      = 32;
  localparam int unsigned NUM_SLICES = 2;
  localparam int unsigned U          = 1;
  localparam int unsigned LANE_W     = $clog2(LANES);
  localparam int unsigned IDX_W      = $clog2(LANES * NUM_SLICES);
  localparam int unsigned RD_W       = LANES * SM_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WT   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Wrap-around metric compare: a < b when (a - b) mod 2^SM_W has its MSB set.
  function automatic logic mod_lt(input logic [SM_W-1:0] a, input logic [SM_W-1:0] b);
    logic [SM_W-1:0] diff;
    diff = a - b;
    return diff[SM_W-1];
  endfunction

endpackage

// File: rtl/pm_min_reduce.sv
// Combinational LANES-way modular-min tree; lower lane wins on ties.
module pm_min_reduce
  import pm_min_scheduler_pkg::*;
(
  input  logic [RD_W-1:0]   pm_slice,
  output logic [SM_W-1:0]   min_pm_c,
  output logic [LANE_W-1:0] min_lane_c
);

  // Heap layout: node i has children 2i+1 (lower lanes) and 2i+2; leaves hold lanes in order.
  localparam int unsigned NODES = 2 * LANES - 1;

  logic [SM_W-1:0]   node_pm   [NODES];
  logic [LANE_W-1:0] node_lane [NODES];

  // Fill leaves, then fold pairwise from the bottom level up to the root.
  always_comb begin
    for (int i = 0; i < int'(NODES); i++) begin
      node_pm[i]   = '0;
      node_lane[i] = '0;
    end
    for (int j = 0; j < int'(LANES); j++) begin
      node_pm[int'(LANES) - 1 + j]   = pm_slice[j*SM_W +: SM_W];
      node_lane[int'(LANES) - 1 + j] = LANE_W'(j);
    end
    for (int i = int'(LANES) - 2; i >= 0; i--) begin
      // Right child replaces left only when strictly less, so ties keep the lower lane.
      if (mod_lt(node_pm[2*i+2], node_pm[2*i+1])) begin
        node_pm[i]   = node_pm[2*i+2];
        node_lane[i] = node_lane[2*i+2];
      end else begin
        node_pm[i]   = node_pm[2*i+1];
        node_lane[i] = node_lane[2*i+1];
      end
    end
  end

  assign min_pm_c   = node_pm[0];
  assign min_lane_c = node_lane[0];

endmodule

// File: rtl/pm_min_scheduler.sv
// Scans the path-metric store slice by slice and reports the minimum-metric state.
module pm_min_scheduler
  import pm_min_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pm_rd_en,
  output logic [U-1:0]      pm_rd_slice,
  input  logic [RD_W-1:0]   pm_rd_data,
  output logic [IDX_W-1:0]  min_state,
  output logic [SM_W-1:0]   min_pm
);

  state_e            state_q, state_d;
  logic [U-1:0]      cnt_q, cnt_d;
  logic [SM_W-1:0]   best_pm_q, best_pm_d;
  logic [IDX_W-1:0]  best_state_q, best_state_d;
  logic [IDX_W-1:0]  min_state_q, min_state_d;
  logic [SM_W-1:0]   min_pm_q, min_pm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [U-1:0]      rd_slice_q, rd_slice_d;

  logic [SM_W-1:0]   red_pm;
  logic [LANE_W-1:0] red_lane;
  logic [IDX_W-1:0]  cand_state;
  logic              last_slice;

  pm_min_reduce u_reduce (
    .pm_slice   (pm_rd_data),
    .min_pm_c   (red_pm),
    .min_lane_c (red_lane)
  );

  assign last_slice = (cnt_q == U'(NUM_SLICES - 1));
  assign cand_state = {cnt_q, red_lane};

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      best_pm_q    <= '0;
      best_state_q <= '0;
      min_state_q  <= '0;
      min_pm_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_slice_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_pm_q    <= best_pm_d;
      best_state_q <= best_state_d;
      min_state_q  <= min_state_d;
      min_pm_q     <= min_pm_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      rd_slice_q   <= rd_slice_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RD;
      ST_RD:   state_d = ST_WT;
      ST_WT:   state_d = last_slice ? ST_DONE : ST_RD;
      ST_DONE: state_d = start ? ST_RD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Slice counter, running best and published result.
  always_comb begin
    cnt_d        = cnt_q;
    best_pm_d    = best_pm_q;
    best_state_d = best_state_q;
    min_state_d  = min_state_q;
    min_pm_d     = min_pm_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) cnt_d = '0;
      end
      ST_WT: begin
        // Earlier slice keeps a tie because replacement needs strictly less.
        if ((cnt_q == '0) || mod_lt(red_pm, best_pm_q)) begin
          best_pm_d    = red_pm;
          best_state_d = cand_state;
        end
        if (last_slice) begin
          min_pm_d    = best_pm_d;
          min_state_d = best_state_d;
        end else begin
          cnt_d = cnt_q + U'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    rd_slice_d = '0;
    unique case (state_d)
      ST_RD: begin
        busy_d     = 1'b1;
        rd_en_d    = 1'b1;
        rd_slice_d = cnt_d;
      end
      ST_WT:   busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pm_rd_en    = rd_en_q;
  assign pm_rd_slice = rd_slice_q;
  assign min_state   = min_state_q;
  assign min_pm      = min_pm_q;

endmodule

// File: doc/pm_min_scheduler.md
# pm_min_scheduler

Sequences the search for the minimum path metric across all trellis states of the Viterbi decoder and reports the winning state to traceback. It reads the path-metric store one slice (32 lanes) at a time. It reduces each slice through a 32-way modular-compare tree and keeps a running best across slices. Sits between the ACS/path-metric memory and the traceback unit, triggered once per decoded block.

## Interface
- SM_W, 8: path-metric width; metrics are modular (wrap-around) values.
- LANES, 32: metrics per slice read; read word is LANES*SM_W bits.
- NUM_SLICES, 2: slices per scan; total states = LANES*NUM_SLICES (64).
- U, 1: slice-select width, ceil(log2(NUM_SLICES)).
- IDX_W, 6: state-index width, log2(LANES*NUM_SLICES); derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; min_state and min_pm are valid.
- pm_rd_en  out  1  read strobe to path-metric store.
- pm_rd_slice  out  U  slice address of the read.
- pm_rd_data  in  LANES*SM_W  read data, valid exactly 1 cycle after pm_rd_en; lane j = bits [j*SM_W+SM_W-1 : j*SM_W].
- min_state  out  IDX_W  global minimum state index = slice*LANES + lane.
- min_pm  out  SM_W  metric of min_state.

## Operation
- Modular compare: a is less than b iff MSB of (a - b) mod 2^SM_W is 1. Equal values are never "less".
- In-slice tie: the lower lane wins. Cross-slice tie: the earlier slice wins. The running best is replaced only when the new value is strictly less.
- FSM states: IDLE, RD, WT, DONE.
  - IDLE: start=1 -> RD, slice counter=0.
  - RD: pm_rd_en=1, pm_rd_slice=counter -> WT.
  - WT: reduce pm_rd_data. For slice 0, load best unconditionally; otherwise update best if strictly less. If counter==NUM_SLICES-1 -> DONE, else counter+1 -> RD.
  - DONE: done=1. start=1 -> RD (back-to-back scan), else -> IDLE.
- min_state and min_pm are registered. They update only on the WT of the last slice (copied from best) and hold until the next completed scan. Intermediate best is internal.
- start while busy (RD/WT) is ignored; the scan in progress is not disturbed.
- pm_rd_en and pm_rd_slice are driven only in RD; pm_rd_slice=0 otherwise.
- Reset (async, any state): FSM=IDLE, counter=0, best=0, busy=0, done=0, pm_rd_en=0, pm_rd_slice=0, min_state=0, min_pm=0. A scan interrupted by reset produces no done.

## Timing
- start sampled at edge k. RD covers cycle k+1; WT covers k+2. For the 2-slice default, RD(1) is k+3, WT(1) is k+4, and DONE is k+5.
- Latency, start to done: 2*NUM_SLICES+1 cycles (5 at default).
- busy=1 in RD and WT, 0 in IDLE and DONE.
- Throughput: one scan per 2*NUM_SLICES+1 cycles with start held or re-pulsed in DONE.
- The reduction tree is purely combinational within WT: five levels of compare-and-select. It must meet one cycle at the target clock.

## Structure
- Shared package/defines: SM_W, LANES, NUM_SLICES, U, IDX_W, the FSM state encoding, and a modular-less-than function reused by the ACS normalisation logic.
- One sub-module, pm_min_reduce: combinational LANES-way tree, log2(LANES) levels of pairwise compare-select carrying lane indices. Outputs min value and lane index with the lower-lane-on-tie rule.
- Top level holds the FSM, slice counter, best registers and output registers.

## Test plan
- Ramp: slice 0 lane j = 100+j, slice 1 lane j = 50+j, start -> done at k+5, min_state=32, min_pm=50; busy high k+1..k+4.
- Ties: all 64 metrics = 7 -> min_state=0, min_pm=7. Then slice 0 = 9 everywhere, slice 1 lanes 5 and 20 = 3 -> min_state=37, min_pm=3.
- Wrap-around: slice 0 lane 3 = 250, all other metrics = 4 -> min_state=3, min_pm=250 (250 - 4 = 246, MSB set). Also check a lone 130 versus 4 elsewhere -> 4 wins.
- Start while busy: pulse start at k+2 -> ignored; exactly one done at k+5 and no extra reads. start held through DONE -> second scan RD at k+6, done at k+10.
- Reset mid-scan: deassert rst_n during WT(0) -> all outputs 0 immediately, no done. A fresh start then gives correct results at k'+5.
- Read handshake: checker asserts pm_rd_en only in RD, with pm_rd_slice = 0 then 1, and data consumed exactly 1 cycle later.
